// File: rtl/afu_rd_pkg.sv
`default_nettype none
// ============================================================================
// afu_rd_pkg : shared types and constants for the AFU read-request engine
// Revision   : 1.0
// ============================================================================
package afu_rd_pkg;

    localparam int CL_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/afu_rd_credit.sv
`default_nettype none
// ============================================================================
// afu_rd_credit : in-flight request tracker and issue-credit check
// Revision      : 1.0
// ============================================================================
module afu_rd_credit
    import afu_rd_pkg::*;
#(
    parameter int BUFF_DEPTH_BITS = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue,
    input  logic                       write,
    input  logic [BUFF_DEPTH_BITS-1:0] input_fifo_count,
    input  logic                       input_fifo_full,
    output logic [BUFF_DEPTH_BITS:0]   outstanding,
    output logic                       can_issue
);

    localparam int CW = BUFF_DEPTH_BITS + 1;
    localparam logic [CW-1:0] DEPTH   = CW'(2 ** BUFF_DEPTH_BITS);
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] committed;

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !write) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && write && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // A full FIFO reports count 0, so full must stand in for the missing MSB.
    assign occupancy = input_fifo_full ? DEPTH : {1'b0, input_fifo_count};
    assign committed = outstanding_q + occupancy;
    assign can_issue = (outstanding_q < MAX_OUT) && (committed < DEPTH);
    assign outstanding = outstanding_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/afu_read_ctrl.sv
`default_nettype none
// ============================================================================
// afu_read_ctrl : credit-limited cache-line read engine feeding the AFU FIFO
// Option AFU_RD_PERF_EN adds stall / busy cycle counters.
// Revision      : 1.0
// ============================================================================
module afu_read_ctrl
    import afu_rd_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BUFF_DEPTH_BITS = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_BITS        = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [31:0]                ctx_length,
    output logic                       rd_req_valid,
    output logic [ADDR_WIDTH-1:0]      rd_req_addr,
    output logic [TAG_BITS-1:0]        rd_req_tag,
    input  logic                       rd_req_almost_full,
    input  logic                       rd_rsp_valid,
    input  logic [CL_WIDTH-1:0]        rd_rsp_data,
    output logic [CL_WIDTH-1:0]        input_fifo_din,
    output logic                       input_fifo_we,
    input  logic [BUFF_DEPTH_BITS-1:0] input_fifo_count,
    input  logic                       input_fifo_full,
`ifdef AFU_RD_PERF_EN
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_total_cycles,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       err_overflow
);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           req_cnt_q, req_cnt_d;
    logic [31:0]           rsp_cnt_q, rsp_cnt_d;
    logic                  rd_req_valid_q, rd_req_valid_d;
    logic [ADDR_WIDTH-1:0] rd_req_addr_q, rd_req_addr_d;
    logic [TAG_BITS-1:0]   rd_req_tag_q, rd_req_tag_d;
    logic                  fifo_we_q, fifo_we_d;
    logic [CL_WIDTH-1:0]   fifo_din_q, fifo_din_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef AFU_RD_PERF_EN
    logic [31:0]           stall_q, stall_d;
    logic [31:0]           total_q, total_d;
`endif

    logic                     can_issue;
    logic                     issue;
    logic                     write;
    logic                     drain_done;
    logic [BUFF_DEPTH_BITS:0] outstanding;

    assign write = fifo_we_q;
    assign issue = (state_q == REQ) && (req_cnt_q < len_q) && !rd_req_almost_full && can_issue;

    afu_rd_credit #(
        .BUFF_DEPTH_BITS (BUFF_DEPTH_BITS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk              (clk),
        .reset            (reset),
        .issue            (issue),
        .write            (write),
        .input_fifo_count (input_fifo_count),
        .input_fifo_full  (input_fifo_full),
        .outstanding      (outstanding),
        .can_issue        (can_issue)
    );

    // Look at post-write counts so done follows the final write by one cycle.
    assign drain_done = (rsp_cnt_d == len_q) &&
                        ((outstanding == '0) || ((outstanding == 1) && write));

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        len_d          = len_q;
        req_cnt_d      = req_cnt_q;
        rsp_cnt_d      = rsp_cnt_q;
        rd_req_valid_d = 1'b0;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_tag_d   = rd_req_tag_q;
        fifo_we_d      = rd_rsp_valid;
        fifo_din_d     = rd_rsp_data;
        done_d         = done_q;
        err_d          = err_q | (rd_rsp_valid && (outstanding == '0)) | (write && input_fifo_full);
`ifdef AFU_RD_PERF_EN
        stall_d        = stall_q;
        total_d        = total_q;
        if (state_q == REQ && !issue) begin
            stall_d = sat_inc32(stall_q);
        end
        if (state_q == REQ || state_q == DRAIN) begin
            total_d = sat_inc32(total_q);
        end
`endif

        if (write) begin
            rsp_cnt_d = rsp_cnt_q + 32'd1;
        end

        if (issue) begin
            rd_req_valid_d = 1'b1;
            rd_req_addr_d  = base_q + ADDR_WIDTH'(req_cnt_q);
            rd_req_tag_d   = req_cnt_q[TAG_BITS-1:0];
            req_cnt_d      = req_cnt_q + 32'd1;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
`ifdef AFU_RD_PERF_EN
                    stall_d = '0;
                    total_d = '0;
`endif
                    if (ctx_length == 32'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        base_d    = base_addr;
                        len_d     = ctx_length;
                        req_cnt_d = '0;
                        rsp_cnt_d = '0;
                        done_d    = 1'b0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (req_cnt_q == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            base_q         <= '0;
            len_q          <= '0;
            req_cnt_q      <= '0;
            rsp_cnt_q      <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_tag_q   <= '0;
            fifo_we_q      <= 1'b0;
            fifo_din_q     <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef AFU_RD_PERF_EN
            stall_q        <= '0;
            total_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            len_q          <= len_d;
            req_cnt_q      <= req_cnt_d;
            rsp_cnt_q      <= rsp_cnt_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_tag_q   <= rd_req_tag_d;
            fifo_we_q      <= fifo_we_d;
            fifo_din_q     <= fifo_din_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef AFU_RD_PERF_EN
            stall_q        <= stall_d;
            total_q        <= total_d;
`endif
        end
    end

    assign rd_req_valid   = rd_req_valid_q;
    assign rd_req_addr    = rd_req_addr_q;
    assign rd_req_tag     = rd_req_tag_q;
    assign input_fifo_we  = fifo_we_q;
    assign input_fifo_din = fifo_din_q;
    assign busy           = (state_q == REQ) || (state_q == DRAIN);
    assign done           = done_q;
    assign err_overflow   = err_q;
`ifdef AFU_RD_PERF_EN
    assign perf_stall_cycles = stall_q;
    assign perf_total_cycles = total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_afu_read_ctrl.sv
`default_nettype none
// ============================================================================
// tb_afu_read_ctrl : directed/randomized bench with memory and FIFO models
// Revision         : 1.0
// ============================================================================
module tb_afu_read_ctrl;
    import afu_rd_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base_addr;
    logic [31:0]  ctx_length;
    logic         rd_req_valid;
    logic [31:0]  rd_req_addr;
    logic [7:0]   rd_req_tag;
    logic         rd_req_almost_full;
    logic         rd_rsp_valid;
    logic [511:0] rd_rsp_data;
    logic [511:0] input_fifo_din;
    logic         input_fifo_we;
    logic [2:0]   input_fifo_count;
    logic         input_fifo_full;
    logic         busy;
    logic         done;
    logic         err_overflow;
`ifdef AFU_RD_PERF_EN
    logic [31:0]  perf_stall_cycles;
    logic [31:0]  perf_total_cycles;
`endif

    always #5 clk = ~clk;

    afu_read_ctrl #(
        .ADDR_WIDTH      (32),
        .BUFF_DEPTH_BITS (3),
        .MAX_OUTSTANDING (4),
        .TAG_BITS        (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .base_addr          (base_addr),
        .ctx_length         (ctx_length),
        .rd_req_valid       (rd_req_valid),
        .rd_req_addr        (rd_req_addr),
        .rd_req_tag         (rd_req_tag),
        .rd_req_almost_full (rd_req_almost_full),
        .rd_rsp_valid       (rd_rsp_valid),
        .rd_rsp_data        (rd_rsp_data),
        .input_fifo_din     (input_fifo_din),
        .input_fifo_we      (input_fifo_we),
        .input_fifo_count   (input_fifo_count),
        .input_fifo_full    (input_fifo_full),
`ifdef AFU_RD_PERF_EN
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_total_cycles  (perf_total_cycles),
`endif
        .busy               (busy),
        .done               (done),
        .err_overflow       (err_overflow)
    );

    int nassert = 0;
    int nfail   = 0;
    int cyc     = 0;

    logic [31:0]  exp_addr_q[$];
    logic [511:0] exp_data_q[$];
    int           rsp_time_q[$];
    logic [31:0]  rsp_addr_q[$];

    int          occ;
    int          out_m;
    int          issued;
    int          writes;
    int          last_we_cyc;
    int          last_rsp_time;
    int          lat_min;
    int          lat_max;
    bit          drain;
    bit          af_drive;
    bit          prev_af;
    logic [31:0] seed;

    function automatic logic [511:0] line_data(input logic [31:0] a, input logic [31:0] s);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = (a ^ s) + 32'(i) * 32'h9E37_79B9;
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        nassert++;
        assert (act === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected transfer: lines base..base+len-1 in order, tags = request index.
    task automatic new_xfer(input logic [31:0] base, input int len, input int lmin, input int lmax);
        exp_addr_q.delete();
        exp_data_q.delete();
        seed    = $urandom;
        lat_min = lmin;
        lat_max = lmax;
        issued  = 0;
        writes  = 0;
        for (int i = 0; i < len; i++) begin
            exp_addr_q.push_back(base + 32'(i));
            exp_data_q.push_back(line_data(base + 32'(i), seed));
        end
    endtask

    task automatic step();
        logic wr;
        logic rdf;
        int   t;
        logic [31:0] a;
        @(negedge clk);
        cyc++;
        if (prev_af) chk("req_during_almost_full", {511'b0, rd_req_valid}, 512'd0);
        if (rd_req_valid === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_req", 512'd1, 512'd0);
            end else begin
                a = exp_addr_q.pop_front();
                chk("req_addr", {480'b0, rd_req_addr}, {480'b0, a});
                chk("req_tag", {504'b0, rd_req_tag}, {504'b0, 8'(issued)});
            end
            issued++;
            out_m++;
            t = cyc + int'($urandom_range(lat_max, lat_min));
            if (t <= last_rsp_time) t = last_rsp_time + 1;
            last_rsp_time = t;
            rsp_time_q.push_back(t);
            rsp_addr_q.push_back(rd_req_addr);
        end
        wr = (input_fifo_we === 1'b1);
        if (wr) begin
            writes++;
            last_we_cyc = cyc;
            if (exp_data_q.size() == 0) chk("unexpected_write", 512'd1, 512'd0);
            else chk("write_data", input_fifo_din, exp_data_q.pop_front());
            if (out_m > 0) out_m--;
        end
        rdf = drain && (occ > 0);
        input_fifo_count = 3'(occ);
        input_fifo_full  = (occ == 8);
        occ = occ - int'(rdf) + int'(wr);
        if (occ > 8) occ = 8;
        chk("credit_bound", {511'b0, (out_m + occ) <= 8}, 512'd1);
        chk("max_outstanding", {511'b0, out_m <= 4}, 512'd1);
        if (rsp_time_q.size() > 0 && rsp_time_q[0] <= cyc) begin
            void'(rsp_time_q.pop_front());
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = line_data(rsp_addr_q.pop_front(), seed);
        end else begin
            rd_rsp_valid = 1'b0;
            rd_rsp_data  = '0;
        end
        prev_af            = af_drive;
        rd_req_almost_full = af_drive;
    endtask

    task automatic pulse_start(input logic [31:0] base, input int len);
        start      = 1'b1;
        base_addr  = base;
        ctx_length = 32'(len);
        step();
        start      = 1'b0;
        base_addr  = $urandom;
        ctx_length = $urandom;
    endtask

    task automatic run_until_done(input int limit);
        int t0;
        t0 = cyc;
        while (done !== 1'b1 && (cyc - t0) < limit) step();
        chk("done_within_budget", {511'b0, done}, 512'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_valid"}, {511'b0, rd_req_valid}, 512'd0);
        chk({tag, "_req_addr"}, {480'b0, rd_req_addr}, 512'd0);
        chk({tag, "_req_tag"}, {504'b0, rd_req_tag}, 512'd0);
        chk({tag, "_fifo_we"}, {511'b0, input_fifo_we}, 512'd0);
        chk({tag, "_fifo_din"}, input_fifo_din, 512'd0);
        chk({tag, "_busy"}, {511'b0, busy}, 512'd0);
        chk({tag, "_done"}, {511'b0, done}, 512'd0);
        chk({tag, "_err"}, {511'b0, err_overflow}, 512'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; ctx_length = '0;
        rd_req_almost_full = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
        input_fifo_count = '0; input_fifo_full = 1'b0;
        occ = 0; out_m = 0; issued = 0; writes = 0; last_we_cyc = 0; last_rsp_time = 0;
        lat_min = 3; lat_max = 3; drain = 1'b1; af_drive = 1'b0; prev_af = 1'b0; seed = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        repeat (2) step();

        // Zero-length transfer: no requests, done the cycle after start.
        new_xfer(32'h0000_2000, 0, 1, 1);
        pulse_start(32'h0000_2000, 0);
        chk("len0_done", {511'b0, done}, 512'd1);
        chk("len0_busy", {511'b0, busy}, 512'd0);
        repeat (5) step();
        chk("len0_no_requests", 512'(issued), 512'd0);

        // 16 lines at 0x100, fixed latency 3, FIFO drained every cycle.
        new_xfer(32'h0000_0100, 16, 3, 3);
        pulse_start(32'h0000_0100, 16);
        chk("start_clears_done", {511'b0, done}, 512'd0);
        chk("first_req_not_yet", {511'b0, rd_req_valid}, 512'd0);
        step();
        chk("first_req_latency2", {511'b0, rd_req_valid}, 512'd1);
        repeat (3) step();
        pulse_start(32'h0000_5000, 3);
        run_until_done(400);
        chk("done_one_after_last_write", 512'(cyc), 512'(last_we_cyc + 1));
        chk("t1_issued", 512'(issued), 512'd16);
        chk("t1_writes", 512'(writes), 512'd16);
        chk("t1_req_left", 512'(exp_addr_q.size()), 512'd0);
        chk("t1_busy", {511'b0, busy}, 512'd0);
        chk("t1_err", {511'b0, err_overflow}, 512'd0);

        // 20 lines, FIFO never read: issue must stop at the FIFO depth.
        drain = 1'b0;
        new_xfer($urandom, 20, 2, 8);
        pulse_start(exp_addr_q[0], 20);
        repeat (150) step();
        chk("t2_issued_stops_at_depth", 512'(issued), 512'd8);
        chk("t2_writes_stop_at_depth", 512'(writes), 512'd8);
        chk("t2_fifo_full", 512'(occ), 512'd8);
        chk("t2_still_busy", {511'b0, busy}, 512'd1);
        chk("t2_err", {511'b0, err_overflow}, 512'd0);
        drain = 1'b1;
        run_until_done(600);
        chk("t2_writes_total", 512'(writes), 512'd20);

        // Backpressure window of 10 cycles in the middle of a transfer.
        new_xfer($urandom, 24, 1, 6);
        pulse_start(exp_addr_q[0], 24);
        repeat (6) step();
        af_drive = 1'b1;
        repeat (10) step();
        af_drive = 1'b0;
        run_until_done(600);
        chk("t3_writes", 512'(writes), 512'd24);
        chk("t3_req_left", 512'(exp_addr_q.size()), 512'd0);

        // Address wrap at the top of the address space.
        new_xfer(32'hFFFF_FFFE, 4, 1, 4);
        pulse_start(32'hFFFF_FFFE, 4);
        run_until_done(200);
        chk("wrap_writes", 512'(writes), 512'd4);
        chk("wrap_req_left", 512'(exp_addr_q.size()), 512'd0);
        chk("wrap_err", {511'b0, err_overflow}, 512'd0);

        // Reset mid-transfer, then a stray response.
        new_xfer($urandom, 10, 3, 6);
        pulse_start(exp_addr_q[0], 10);
        for (int i = 0; i < 100 && issued < 5; i++) step();
        chk("t6_reached_req5", 512'(issued), 512'd5);
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        exp_addr_q.delete(); exp_data_q.delete();
        rsp_time_q.delete(); rsp_addr_q.delete();
        out_m = 0; occ = 0; last_rsp_time = cyc;
        repeat (2) step();
        reset = 1'b1;
        step();
        rsp_time_q.push_back(cyc + 1);
        rsp_addr_q.push_back(32'hDEAD_0000);
        exp_data_q.push_back(line_data(32'hDEAD_0000, seed));
        out_m  = 1;
        writes = 0;
        repeat (3) step();
        chk("stray_written", 512'(writes), 512'd1);
        chk("stray_sets_err", {511'b0, err_overflow}, 512'd1);
        chk("after_abort_busy", {511'b0, busy}, 512'd0);
        chk("after_abort_done", {511'b0, done}, 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/afu_read_ctrl.md
# afu_read_ctrl

Upstream read-request engine for the FFT convolution AFU. Issues `ctx_length` sequential cache-line read requests to the host memory interface and forwards the 512-bit read responses into the AFU input FIFO. Request issue is credit-limited so the input FIFO can never overflow, whatever the memory latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: cache-line address width.
- `BUFF_DEPTH_BITS`, 3: input FIFO depth is 2**BUFF_DEPTH_BITS entries. Must match the downstream FIFO.
- `MAX_OUTSTANDING`, 4: maximum number of in-flight requests, 1..2**BUFF_DEPTH_BITS.
- `TAG_BITS`, 8: request tag width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a transfer.
- `base_addr` in ADDR_WIDTH: first cache-line address, sampled on `start`.
- `ctx_length` in 32: number of lines to read, sampled on `start`.
- `rd_req_valid` out 1: read request, valid for one cycle.
- `rd_req_addr` out ADDR_WIDTH: request line address.
- `rd_req_tag` out TAG_BITS: low TAG_BITS bits of the request index.
- `rd_req_almost_full` in 1: memory-side backpressure; no request is issued while it is high.
- `rd_rsp_valid` in 1: response valid.
- `rd_rsp_data` in 512: response cache line.
- `input_fifo_din` out 512: data to the input FIFO.
- `input_fifo_we` out 1: input FIFO write enable.
- `input_fifo_count` in BUFF_DEPTH_BITS: input FIFO occupancy.
- `input_fifo_full` in 1: input FIFO full.
- `busy` out 1: a transfer is in progress.
- `done` out 1: the last line has been written. Held until the next `start`.
- `err_overflow` out 1: sticky protocol error flag.

## Operation
- FSM states: IDLE, REQ, DRAIN, DONE.
  - IDLE or DONE, on `start`: if `ctx_length`==0, go to DONE. Otherwise latch the inputs, clear the counters and `done`, and go to REQ.
  - REQ to DRAIN when `req_cnt`==`ctx_length`.
  - DRAIN to DONE when `outstanding`==0 and `rsp_cnt`==`ctx_length`.
  - `start` is ignored in REQ and DRAIN.
- Issue condition, evaluated in REQ:
  - `req_cnt` < `ctx_length`,
  - `!rd_req_almost_full`,
  - `outstanding` < MAX_OUTSTANDING,
  - `outstanding` + `input_fifo_count` < 2**BUFF_DEPTH_BITS. This sum is computed at BUFF_DEPTH_BITS+1 bits.
- On issue, the following update at the same edge:
  - `rd_req_valid`<=1,
  - `rd_req_addr`<=`base_addr`+`req_cnt`, wrapping modulo 2**ADDR_WIDTH,
  - `rd_req_tag`<=`req_cnt`[TAG_BITS-1:0],
  - `req_cnt`++,
  - `outstanding`++.
- Responses are accepted unconditionally:
  - registered `input_fifo_we`<=`rd_rsp_valid` and `input_fifo_din`<=`rd_rsp_data`;
  - on each write, `outstanding`-- and `rsp_cnt`++.
- Same-cycle issue and write: `outstanding` is unchanged.
- `err_overflow` is set if `rd_rsp_valid` arrives with `outstanding`==0, or if a write occurs while `input_fifo_full`. The flag is cleared only by reset. The data is still forwarded.
- Responses are assumed to arrive in order. Tags are for debug only.
- `busy` = state is REQ or DRAIN.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Latency from `start` to the first `rd_req_valid` is 2 cycles: latch, then issue.
- `rd_rsp_valid` to `input_fifo_we` is 1 cycle.
- Maximum issue rate is 1 request per cycle. Requests pause the cycle after `rd_req_almost_full` rises.
- `done` rises 1 cycle after the final `input_fifo_we` edge.
- With `ctx_length`==0, `done` is high 1 cycle after `start`.
- Reset asserted mid-transfer aborts immediately. In-flight responses arriving after reset release are written (harmless) and flag `err_overflow`.

## Configuration
- `AFU_RD_PERF_EN` defined: adds outputs `perf_stall_cycles` (32) and `perf_total_cycles` (32).
  - `perf_stall_cycles` counts REQ cycles in which the issue condition fails.
  - `perf_total_cycles` counts all `busy` cycles.
  - Both clear on `start` and saturate at 2**32-1.
- Undefined: both ports and the counters are absent.

## Structure
- Package `afu_rd_pkg` holds:
  - the state enum `rd_state_t`,
  - the line width constant `CL_WIDTH`=512.
- Sub-module `afu_rd_credit`:
  - owns `outstanding`, updating on issue and write;
  - exposes `can_issue`, computed from MAX_OUTSTANDING and `input_fifo_count`.

## Test plan
- ctx_length=16, base_addr=0x100, fixed 3-cycle response latency, FIFO drained every cycle -> 16 requests at addresses 0x100..0x10F with tags 0..15; 16 writes with data in order; `done`=1; `err_overflow`=0.
- ctx_length=20, FIFO never read -> requests stop at exactly 8 writes (BUFF_DEPTH_BITS=3); `outstanding`+`count` never exceeds 8; no overflow.
- `rd_req_almost_full` held high for 10 cycles mid-transfer -> no `rd_req_valid` during the window (one-cycle lag); issue resumes afterwards and all lines complete.
- ctx_length=0 -> no requests; `done`=1 one cycle after `start`. A second `start` asserted while busy -> ignored.
- base_addr=0xFFFFFFFE, ctx_length=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Reset pulsed mid-transfer at request 5 -> all outputs 0 and state IDLE; a stray response afterwards sets `err_overflow`.
